// File: rtl/uart_pkg.sv
// Shared types for the UART receive path: the per-word error tag carried
// alongside each received data byte.
package uart_pkg;

  typedef struct packed {
    logic overrun;
    logic parity;
    logic framing;
  } uart_err_t;

  localparam int UART_ERR_W = $bits(uart_err_t);

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Read/write pointer control for a power-of-two FIFO: accept logic, fill level,
// full/empty and single-cycle flush. Storage lives in the instantiating module.
module fifo_ptr_ctrl #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          wr_en_i,
  input  logic          rd_en_i,
  output logic          push_o,
  output logic          pop_o,
  output logic [AW-1:0] wr_addr_o,
  output logic [AW-1:0] rd_addr_o,
  output logic [CW-1:0] level_o,
  output logic [CW-1:0] next_level_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [CW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] rd_ptr_q, rd_ptr_d;

  assign level_o   = wr_ptr_q - rd_ptr_q;
  assign empty_o   = (level_o == '0);
  assign full_o    = (level_o == DEPTH_C);
  assign wr_addr_o = wr_ptr_q[AW-1:0];
  assign rd_addr_o = rd_ptr_q[AW-1:0];

  // A pop frees the head slot this cycle, so a push into a full FIFO is
  // still safe when paired with a pop.
  assign push_o = !flush_i && wr_en_i && (!full_o || rd_en_i);
  assign pop_o  = !flush_i && rd_en_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q + CW'(push_o);
    rd_ptr_d = flush_i ? wr_ptr_q : rd_ptr_q + CW'(pop_o);
  end

  assign next_level_o = wr_ptr_d - rd_ptr_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: first-word-fall-through FIFO of {err,data} words with
// fill level, threshold interrupt, sticky overflow and synchronous flush.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int ERR_W  = UART_ERR_W,
  parameter  int DEPTH  = 16,
  localparam int AW     = $clog2(DEPTH),
  localparam int CW     = AW + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [ERR_W-1:0]  wr_err_i,
  input  logic              rd_en_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [ERR_W-1:0]  rd_err_o,
  output logic              empty_o,
  output logic              full_o,
  output logic [CW-1:0]     level_o,
  input  logic [CW-1:0]     thresh_i,
  output logic              thresh_irq_o,
  output logic              overflow_o,
  input  logic              ovf_clr_i
);

  localparam int EW = DATA_W + ERR_W;

  logic          push, pop;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [CW-1:0] next_level;
  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] head;
  logic          drop;
  logic          overflow_q, overflow_d;
  logic          thresh_irq_q, thresh_irq_d;

  fifo_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .flush_i      (flush_i),
    .wr_en_i      (wr_en_i),
    .rd_en_i      (rd_en_i),
    .push_o       (push),
    .pop_o        (pop),
    .wr_addr_o    (wr_addr),
    .rd_addr_o    (rd_addr),
    .level_o      (level_o),
    .next_level_o (next_level),
    .full_o       (full_o),
    .empty_o      (empty_o)
  );

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_addr] <= {wr_err_i, wr_data_i};
  end

  assign head      = mem_q[rd_addr];
  assign rd_data_o = empty_o ? '0 : head[DATA_W-1:0];
  assign rd_err_o  = empty_o ? '0 : head[EW-1:DATA_W];

  assign drop = wr_en_i && full_o && !rd_en_i && !flush_i;

  always_comb begin
    overflow_d = overflow_q;
    if (flush_i || ovf_clr_i) overflow_d = 1'b0;
    else if (drop)            overflow_d = 1'b1;
  end

  // Tracking next_level lets the interrupt line up with level_o, not lag it.
  assign thresh_irq_d = (thresh_i != '0) && (next_level >= thresh_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      overflow_q   <= 1'b0;
      thresh_irq_q <= 1'b0;
    end else begin
      overflow_q   <= overflow_d;
      thresh_irq_q <= thresh_irq_d;
    end
  end

  assign overflow_o   = overflow_q;
  assign thresh_irq_o = thresh_irq_q;

  // pop is consumed inside the pointer block; kept as a named net for debug.
  logic unused_pop;
  assign unused_pop = pop;

endmodule
